// File: rtl/cb_config_sequencer.sv
// Config-bus write sequencer: buffers host (addr, data, last) words in a small FIFO
// and replays each one as a single-cycle config_en write, with optional idle gaps.
module cb_config_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 0,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] config_addr,
  output logic [DATA_W-1:0] config_data,
  output logic              config_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cfg_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WORD_W = ADDR_W + DATA_W + 1;
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  state_t            state_q;
  logic [GAP_W-1:0]  gap_q;
  logic              en_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       cnt_q;

  logic fifo_empty_s, push_s, can_pop_s, pop_s;
  logic [WORD_W-1:0] head_s;

  assign fifo_empty_s = (count_q == '0);
  assign in_ready     = (count_q < DEPTH_C) && !flush;
  assign push_s       = in_valid && in_ready;
  // A pop is allowed from IDLE, back-to-back from ISSUE, or on the final GAP cycle.
  assign can_pop_s    = (state_q == S_IDLE)
                     || ((state_q == S_ISSUE) && (GAP_CYCLES == 0))
                     || ((state_q == S_GAP) && (gap_q == '0));
  assign pop_s        = !flush && !fifo_empty_s && can_pop_s;
  assign head_s       = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_last, in_addr, in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= 16'd0;
    end else if (flush) begin
      // Address/data deliberately keep the last issued word.
      state_q <= S_IDLE;
      gap_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      if (pop_s) begin
        en_q                     <= 1'b1;
        {done_q, addr_q, data_q} <= head_s;
        cnt_q                    <= (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (pop_s) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (GAP_CYCLES > 0) begin
            state_q <= S_GAP;
            gap_q   <= GAP_INIT;
          end else if (!pop_s) begin
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= pop_s ? S_ISSUE : S_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign config_addr = addr_q;
  assign config_data = data_q;
  assign config_en   = en_q;
  assign done        = done_q;
  assign cfg_count   = cnt_q;
  assign busy        = !fifo_empty_s || (state_q != S_IDLE);

endmodule

// File: tb/tb_cb_config_sequencer.sv
// Directed bench for cb_config_sequencer: three instances cover GAP_CYCLES of 0, 2 and 3.
module tb_cb_config_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] in_addr   [3];
  logic [31:0] in_data   [3];
  logic        in_last   [3];
  logic [31:0] config_addr [3];
  logic [31:0] config_data [3];
  logic        config_en [3];
  logic        busy      [3];
  logic        done      [3];
  logic [15:0] cfg_count [3];

  int passed = 0;
  int total  = 0;
  int pushed, issued, k;
  logic acc;

  always #5 clk = ~clk;

  cb_config_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(0), .ADDR_W(32), .DATA_W(32)) u_gap0 (
    .clk(clk), .reset(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_addr(in_addr[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .config_addr(config_addr[0]), .config_data(config_data[0]), .config_en(config_en[0]),
    .busy(busy[0]), .done(done[0]), .cfg_count(cfg_count[0]));

  cb_config_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(2), .ADDR_W(32), .DATA_W(32)) u_gap2 (
    .clk(clk), .reset(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_addr(in_addr[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .config_addr(config_addr[1]), .config_data(config_data[1]), .config_en(config_en[1]),
    .busy(busy[1]), .done(done[1]), .cfg_count(cfg_count[1]));

  cb_config_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(3), .ADDR_W(32), .DATA_W(32)) u_gap3 (
    .clk(clk), .reset(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_addr(in_addr[2]), .in_data(in_data[2]), .in_last(in_last[2]),
    .config_addr(config_addr[2]), .config_data(config_data[2]), .config_en(config_en[2]),
    .busy(busy[2]), .done(done[2]), .cfg_count(cfg_count[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic l);
    in_valid[idx] = v;
    in_addr[idx]  = a;
    in_data[idx]  = d;
    in_last[idx]  = l;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush[i] = 1'b0;
      drive(i, 1'b0, 32'h0, 32'h0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_en",    config_en[0], 32'd0);
    chk("rst_busy",  busy[0],      32'd0);
    chk("rst_done",  done[0],      32'd0);
    chk("rst_ready", in_ready[0],  32'd1);
    chk("rst_cnt",   cfg_count[0], 32'd0);
    chk("rst_addr",  config_addr[0], 32'd0);

    // Single word: two-edge latency
    drive(0, 1'b1, 32'h10, 32'h1, 1'b1);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("single_en_early", config_en[0], 32'd0);
    chk("single_busy",     busy[0],      32'd1);
    tick();
    chk("single_en",   config_en[0],   32'd1);
    chk("single_addr", config_addr[0], 32'h10);
    chk("single_data", config_data[0], 32'h1);
    chk("single_done", done[0],        32'd1);
    chk("single_cnt",  cfg_count[0],   32'd1);
    tick();
    chk("single_en_off", config_en[0],   32'd0);
    chk("single_done_off", done[0],      32'd0);
    chk("single_idle", busy[0],          32'd0);
    chk("single_hold", config_addr[0],   32'h10);

    // Clear the count, then a back-to-back burst of 4
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    chk("flush_cnt", cfg_count[0], 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, i, 32'h100 + i, i == 3);
      tick();
      if (i > 0) begin
        chk("b2b_en",   config_en[0],   32'd1);
        chk("b2b_addr", config_addr[0], i - 1);
        chk("b2b_data", config_data[0], 32'h100 + i - 1);
        chk("b2b_done", done[0],        32'd0);
      end
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("b2b_last_en",   config_en[0],   32'd1);
    chk("b2b_last_addr", config_addr[0], 32'h3);
    chk("b2b_last_done", done[0],        32'd1);
    chk("b2b_cnt",       cfg_count[0],   32'd4);
    tick();
    chk("b2b_end_en",   config_en[0], 32'd0);
    chk("b2b_end_busy", busy[0],      32'd0);

    // GAP_CYCLES=2: pulses three cycles apart
    k = 0;
    for (int t = 1; t <= 10; t++) begin
      if (t <= 3) drive(1, 1'b1, 32'h20 + t - 1, 32'h200 + t - 1, t == 3);
      else        drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      chk("gap2_en", config_en[1], (t == 2 || t == 5 || t == 8));
      if (config_en[1]) begin
        chk("gap2_addr", config_addr[1], 32'h20 + k);
        chk("gap2_done", done[1], (k == 2));
        k++;
      end
    end
    chk("gap2_cnt", cfg_count[1], 32'd3);

    // GAP_CYCLES=3 with 6 words into a 4-deep FIFO: host stalls, nothing lost
    pushed = 0;
    issued = 0;
    for (int t = 1; t <= 40; t++) begin
      if (pushed < 6) drive(2, 1'b1, 32'h30 + pushed, 32'h300 + pushed, pushed == 5);
      else            drive(2, 1'b0, 32'h0, 32'h0, 1'b0);
      acc = in_valid[2] && in_ready[2];
      tick();
      if (acc) pushed++;
      if (t == 5) chk("stall_ready_low", in_ready[2], 32'd0);
      if (t == 6) chk("stall_ready_back", in_ready[2], 32'd1);
      if (config_en[2]) begin
        chk("stall_order", config_addr[2], 32'h30 + issued);
        chk("stall_data",  config_data[2], 32'h300 + issued);
        chk("stall_done",  done[2], (issued == 5));
        issued++;
      end
    end
    chk("stall_pushed", pushed, 32'd6);
    chk("stall_issued", issued, 32'd6);
    chk("stall_cnt",    cfg_count[2], 32'd6);

    // Flush after two of four writes
    drive(0, 1'b1, 32'h40, 32'h400, 1'b0);
    tick();
    drive(0, 1'b1, 32'h41, 32'h401, 1'b0);
    tick();
    chk("fl_first", config_addr[0], 32'h40);
    drive(0, 1'b1, 32'h42, 32'h402, 1'b0);
    tick();
    chk("fl_second", config_addr[0], 32'h41);
    chk("fl_cnt_pre", cfg_count[0], 32'd6);
    flush[0] = 1'b1;
    drive(0, 1'b1, 32'h43, 32'h403, 1'b1);
    #1;
    chk("fl_ready", in_ready[0], 32'd0);
    tick();
    flush[0] = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("fl_en",   config_en[0],   32'd0);
    chk("fl_busy", busy[0],        32'd0);
    chk("fl_cnt",  cfg_count[0],   32'd0);
    chk("fl_hold", config_addr[0], 32'h41);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("fl_quiet_en",   config_en[0], 32'd0);
      chk("fl_quiet_done", done[0],      32'd0);
    end

    // Asynchronous reset mid-burst
    drive(0, 1'b1, 32'h50, 32'h500, 1'b0);
    tick();
    drive(0, 1'b1, 32'h51, 32'h501, 1'b1);
    tick();
    chk("ar_pre_en", config_en[0], 32'd1);
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_en",    config_en[0], 32'd0);
    chk("ar_busy",  busy[0],      32'd0);
    chk("ar_done",  done[0],      32'd0);
    chk("ar_ready", in_ready[0],  32'd1);
    chk("ar_cnt",   cfg_count[0], 32'd0);
    #2 rst = 1'b0;
    tick();
    chk("ar_lost_en",   config_en[0], 32'd0);
    chk("ar_lost_busy", busy[0],      32'd0);
    drive(0, 1'b1, 32'h60, 32'h600, 1'b1);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("ar_next_en",   config_en[0],   32'd1);
    chk("ar_next_addr", config_addr[0], 32'h60);
    chk("ar_next_done", done[0],        32'd1);
    chk("ar_next_cnt",  cfg_count[0],   32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
